// File: rtl/alu_result_demux8_if.sv
// Result-router bus: one input stream with a lane select, eight held output lanes.
interface alu_result_demux8_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         opsel;
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [3:0]         occupancy;

  modport master (
    output in_valid, in_data, opsel, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_valid, in_data, opsel, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/alu_result_demux8.sv
// Registered 1-to-8 result router: a word is visible on its lane the edge after accept.
// Backpressure is per selected lane only; a full lane refills in the cycle it drains.
module alu_result_demux8 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_demux8_if.slave bus
);

  logic [8*WIDTH-1:0] r_data;
  logic [7:0]         r_valid;
  logic [3:0]         r_occ;

  logic [7:0]         w_wr;
  logic [7:0]         w_drain;
  logic [7:0]         w_next_valid;
  logic [3:0]         w_next_occ;

  // Only the selected lane can stall the input; in_valid is deliberately absent.
  assign bus.in_ready  = !r_valid[bus.opsel] || bus.out_ready[bus.opsel];
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.occupancy = r_occ;

  always_comb begin
    w_wr = '0;
    if (bus.in_valid && bus.in_ready) begin
      w_wr[bus.opsel] = 1'b1;
    end
    w_drain      = r_valid & bus.out_ready;
    w_next_valid = (r_valid & ~w_drain) | w_wr;
    w_next_occ   = '0;
    for (int k = 0; k < 8; k++) begin
      w_next_occ = w_next_occ + {3'b000, w_next_valid[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_next_valid;
      r_occ   <= w_next_occ;
      for (int k = 0; k < 8; k++) begin
        if (w_wr[k]) begin
          r_data[k*WIDTH +: WIDTH] <= bus.in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_demux8.sv
// Bench for alu_result_demux8: vector table, directed corner sequences, random scoreboard.
module tb_alu_result_demux8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  alu_result_demux8_if #(.WIDTH(32)) bus ();

  alu_result_demux8 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [31:0] dat;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_valid;
    logic [3:0]  exp_occ;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] mq [8][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] lane(input int k);
    logic [255:0] d;
    d = bus.out_data;
    return d[k*32 +: 32];
  endfunction

  task automatic wr(input logic [2:0] sel, input logic [31:0] dat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opsel     = sel;
    bus.in_data   = dat;
    bus.out_ready = 8'h00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opsel     = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
    #2;
    chk("reset_valid", {24'd0, bus.out_valid}, 32'h0);
    chk("reset_occ", {28'd0, bus.occupancy}, 32'h0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep fill, then a full-lane stall and a drain-all.
    tbl[0] = '{1'b1, 3'd0, 32'd0, 8'h00, 1'b1, 8'h01, 4'd1};
    tbl[1] = '{1'b1, 3'd1, 32'd1, 8'h00, 1'b1, 8'h03, 4'd2};
    tbl[2] = '{1'b1, 3'd2, 32'd2, 8'h00, 1'b1, 8'h07, 4'd3};
    tbl[3] = '{1'b1, 3'd3, 32'd3, 8'h00, 1'b1, 8'h0F, 4'd4};
    tbl[4] = '{1'b1, 3'd4, 32'd4, 8'h00, 1'b1, 8'h1F, 4'd5};
    tbl[5] = '{1'b1, 3'd5, 32'd5, 8'h00, 1'b1, 8'h3F, 4'd6};
    tbl[6] = '{1'b1, 3'd6, 32'd6, 8'h00, 1'b1, 8'h7F, 4'd7};
    tbl[7] = '{1'b1, 3'd7, 32'd7, 8'h00, 1'b1, 8'hFF, 4'd8};
    tbl[8] = '{1'b1, 3'd0, 32'hAAAA_AAAA, 8'h00, 1'b0, 8'hFF, 4'd8};
    tbl[9] = '{1'b0, 3'd0, 32'd0, 8'hFF, 1'b1, 8'h00, 4'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid  = tbl[i].vld;
      bus.opsel     = tbl[i].sel;
      bus.in_data   = tbl[i].dat;
      bus.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), {24'd0, bus.out_valid}, {24'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_occ", i), {28'd0, bus.occupancy}, {28'd0, tbl[i].exp_occ});
      if (i == 7) begin
        for (int k = 0; k < 8; k++) chk($sformatf("sweep_lane%0d", k), lane(k), k);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("drain_keeps_data", lane(0), 32'd0);

    // Asynchronous reset mid-cycle with lanes 2 and 5 full.
    wr(3'd2, 32'h2222_2222);
    wr(3'd5, 32'h5555_5555);
    chk("pre_reset_valid", {24'd0, bus.out_valid}, 32'h24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {24'd0, bus.out_valid}, 32'h0);
    chk("async_rst_occ", {28'd0, bus.occupancy}, 32'h0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);
    for (int k = 0; k < 8; k++) chk($sformatf("async_rst_lane%0d", k), lane(k), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall on a full lane, then redirect to an empty one.
    wr(3'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opsel    = 3'd3;
    bus.in_data  = 32'h1234_5678;
    #1;
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("stall_lane3", lane(3), 32'hDEAD_BEEF);
    chk("stall_valid", {24'd0, bus.out_valid}, 32'h08);
    @(negedge clk);
    bus.opsel = 3'd4;
    #1;
    chk("redirect_in_ready", {31'd0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("redirect_valid", {24'd0, bus.out_valid}, 32'h18);
    chk("redirect_lane4", lane(4), 32'h1234_5678);

    // Pass-through refill of lane 1.
    wr(3'd1, 32'h1111_1111);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opsel     = 3'd1;
    bus.in_data   = 32'hCAFE_0001;
    bus.out_ready = 8'h02;
    #1;
    chk("refill_in_ready", {31'd0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("refill_valid", {24'd0, bus.out_valid}, 32'h1A);
    chk("refill_lane1", lane(1), 32'hCAFE_0001);
    chk("refill_occ", {28'd0, bus.occupancy}, 32'd3);

    // Three lanes drain while an empty lane is written.
    do_reset();
    wr(3'd0, 32'hA0);
    wr(3'd1, 32'hA1);
    wr(3'd7, 32'hA7);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opsel     = 3'd5;
    bus.in_data   = 32'hA5;
    bus.out_ready = 8'h83;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("multi_valid", {24'd0, bus.out_valid}, 32'h20);
    chk("multi_occ", {28'd0, bus.occupancy}, 32'd1);
    chk("multi_lane5", lane(5), 32'hA5);

    // Random traffic against per-lane FIFO scoreboard.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic        iv;
      logic [2:0]  sel;
      logic [31:0] dat;
      logic [7:0]  ordy;
      logic        erdy;
      logic [7:0]  emask;
      int          eocc;
      iv   = 1'($urandom_range(0, 3) != 0);
      sel  = 3'($urandom_range(0, 7));
      dat  = $urandom;
      ordy = 8'($urandom);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.opsel     = sel;
      bus.in_data   = dat;
      bus.out_ready = ordy;
      #1;
      erdy = (mq[sel].size() == 0) || ordy[sel];
      chk("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, erdy});
      for (int k = 0; k < 8; k++) begin
        if (mq[k].size() > 0 && ordy[k]) begin
          chk($sformatf("rnd_drain_lane%0d", k), lane(k), mq[k][0]);
          void'(mq[k].pop_front());
        end
      end
      if (iv && erdy) mq[sel].push_back(dat);
      @(posedge clk);
      #1;
      emask = '0;
      eocc  = 0;
      for (int k = 0; k < 8; k++) begin
        if (mq[k].size() > 0) begin
          emask[k] = 1'b1;
          eocc += mq[k].size();
          if (k == int'(sel)) chk("rnd_lane_data", lane(k), mq[k][0]);
        end
      end
      chk("rnd_valid", {24'd0, bus.out_valid}, {24'd0, emask});
      chk("rnd_occ", {28'd0, bus.occupancy}, eocc);
      chk("rnd_occ_popcount", {28'd0, bus.occupancy}, $countones(bus.out_valid));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
